// File: rtl/tetris_board_engine.sv
// Tetris playfield store with line-clear scan/shift engine.
// Also tracks score, best score and game over, and serves probe and video read ports.
module tetris_board_engine #(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int CW      = 5,
  parameter int SCORE_W = 16
) (
  input  logic                 VGA_CLK,
  input  logic                 RESET_N,
  input  logic                 clr_game,
  input  logic                 lock_valid,
  output logic                 lock_ready,
  input  logic [4*$clog2(ROWS)-1:0] lock_rows,
  input  logic [4*$clog2(COLS)-1:0] lock_cols,
  input  logic [CW-1:0]        lock_color,
  input  logic [$clog2(ROWS):0] probe_row,
  input  logic [$clog2(COLS):0] probe_col,
  output logic                 probe_occ,
  input  logic [$clog2(ROWS)-1:0] vid_row,
  input  logic [$clog2(COLS)-1:0] vid_col,
  output logic [CW-1:0]        vid_color,
  output logic                 busy,
  output logic                 clear_pulse,
  output logic [2:0]           clear_count,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   best_score,
  output logic                 game_over
);

  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [CW-1:0]   board [ROWS][COLS];
  logic [2:0]      state;
  logic [RW-1:0]   scan_r;
  logic [RW-1:0]   shift_k;
  logic [2:0]      cnt;
  logic [4*RW-1:0]  lk_rows;
  logic [4*CLW-1:0] lk_cols;
  logic [CW-1:0]   lk_color;

  logic            accept;
  logic            clr_ok;
  logic            row_full;
  logic            top_occ;
  logic [RW-1:0]   wr_r [4];
  logic [CLW-1:0]  wr_c [4];
  logic [3:0]      wr_ok;
  logic [3:0]      pts;
  logic [SCORE_W:0] sum;
  logic [SCORE_W-1:0] new_score;
  logic            p_in;
  logic            v_in;

  assign busy       = (state != S_IDLE);
  assign lock_ready = (state == S_IDLE) && !game_over;
  assign accept     = lock_valid && lock_ready;
  assign clr_ok     = clr_game && (state == S_IDLE);

  always_comb begin
    row_full = 1'b1;
    top_occ  = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (board[scan_r][c] == '0) row_full = 1'b0;
      if (board[0][c] != '0) top_occ = 1'b1;
    end
  end

  // Cells landing outside the field are silently dropped.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_r[k]  = lk_rows[k*RW +: RW];
      wr_c[k]  = lk_cols[k*CLW +: CLW];
      wr_ok[k] = ({1'b0, wr_r[k]} < (RW+1)'(ROWS)) &&
                 ({1'b0, wr_c[k]} < (CLW+1)'(COLS));
    end
  end

  always_comb begin
    unique case (cnt)
      3'd0:    pts = 4'd0;
      3'd1:    pts = 4'd1;
      3'd2:    pts = 4'd3;
      3'd3:    pts = 4'd5;
      default: pts = 4'd8;
    endcase
    sum = {1'b0, score} + {{(SCORE_W-3){1'b0}}, pts};
    new_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end

  assign p_in = !probe_row[RW] && !probe_col[CLW] &&
                ({1'b0, probe_row[RW-1:0]} < (RW+1)'(ROWS)) &&
                ({1'b0, probe_col[CLW-1:0]} < (CLW+1)'(COLS));

  assign probe_occ = busy || !p_in ||
                     (board[probe_row[RW-1:0]][probe_col[CLW-1:0]] != '0);

  assign v_in = ({1'b0, vid_row} < (RW+1)'(ROWS)) &&
                ({1'b0, vid_col} < (CLW+1)'(COLS));

  always_ff @(posedge VGA_CLK) begin
    if (!RESET_N) vid_color <= '0;
    else if (v_in) vid_color <= board[vid_row][vid_col];
    else vid_color <= '0;
  end

  always_ff @(posedge VGA_CLK) begin
    if (!RESET_N || clr_ok) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board[r][c] <= '0;
    end else if (state == S_WRITE) begin
      for (int k = 0; k < 4; k++)
        if (wr_ok[k]) board[wr_r[k]][wr_c[k]] <= lk_color;
    end else if (state == S_SHIFT) begin
      for (int c = 0; c < COLS; c++)
        if (shift_k == '0) board[0][c] <= '0;
        else board[shift_k][c] <= board[shift_k - RW'(1)][c];
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (!RESET_N || clr_ok) begin
      state       <= S_IDLE;
      scan_r      <= RW'(ROWS - 1);
      shift_k     <= '0;
      cnt         <= '0;
      lk_rows     <= '0;
      lk_cols     <= '0;
      lk_color    <= '0;
      clear_pulse <= 1'b0;
      clear_count <= '0;
      score       <= '0;
      game_over   <= 1'b0;
      if (!RESET_N) best_score <= '0;
    end else begin
      clear_pulse <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            lk_rows  <= lock_rows;
            lk_cols  <= lock_cols;
            lk_color <= lock_color;
            cnt      <= '0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          scan_r <= RW'(ROWS - 1);
          state  <= S_SCAN;
        end
        S_SCAN: begin
          if (row_full) begin
            shift_k <= scan_r;
            cnt     <= cnt + 3'd1;
            state   <= S_SHIFT;
          end else if (scan_r == '0) begin
            state <= S_DONE;
          end else begin
            scan_r <= scan_r - RW'(1);
          end
        end
        // Return to the same row: the shifted-in row may also be full.
        S_SHIFT: begin
          if (shift_k == '0) state <= S_SCAN;
          else shift_k <= shift_k - RW'(1);
        end
        S_DONE: begin
          clear_pulse <= 1'b1;
          clear_count <= cnt;
          score       <= new_score;
          if (new_score > best_score) best_score <= new_score;
          if (top_occ) game_over <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tetris_board_engine.sv
// Directed bench for tetris_board_engine: locks, clears, scoring,
// game over, probe port and reset during a shift.
module tb_tetris_board_engine;

  localparam int RW  = 5;
  localparam int CLW = 4;

  logic          VGA_CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          clr_game = 1'b0;
  logic          lock_valid = 1'b0;
  logic          lock_ready;
  logic [4*RW-1:0]  lock_rows = '0;
  logic [4*CLW-1:0] lock_cols = '0;
  logic [4:0]    lock_color = '0;
  logic [RW:0]   probe_row = '0;
  logic [CLW:0]  probe_col = '0;
  logic          probe_occ;
  logic [RW-1:0] vid_row = '0;
  logic [CLW-1:0] vid_col = '0;
  logic [4:0]    vid_color;
  logic          busy;
  logic          clear_pulse;
  logic [2:0]    clear_count;
  logic [15:0]   score;
  logic [15:0]   best_score;
  logic          game_over;

  int nchk = 0;
  int nerr = 0;
  int lat;

  tetris_board_engine dut (
    .VGA_CLK     (VGA_CLK),
    .RESET_N     (RESET_N),
    .clr_game    (clr_game),
    .lock_valid  (lock_valid),
    .lock_ready  (lock_ready),
    .lock_rows   (lock_rows),
    .lock_cols   (lock_cols),
    .lock_color  (lock_color),
    .probe_row   (probe_row),
    .probe_col   (probe_col),
    .probe_occ   (probe_occ),
    .vid_row     (vid_row),
    .vid_col     (vid_col),
    .vid_color   (vid_color),
    .busy        (busy),
    .clear_pulse (clear_pulse),
    .clear_count (clear_count),
    .score       (score),
    .best_score  (best_score),
    .game_over   (game_over)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic vid(input int r, input int c, output logic [4:0] v);
    vid_row = RW'(r);
    vid_col = CLW'(c);
    tick();
    v = vid_color;
  endtask

  task automatic sweep(input string tag, input int r0, input int r1);
    int nz;
    logic [4:0] v;
    nz = 0;
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < 10; c++) begin
        vid(r, c, v);
        if (v != 5'd0) nz++;
      end
    chk(tag, nz, 0);
  endtask

  task automatic offer(input int r0, input int c0, input int r1, input int c1,
                       input int r2, input int c2, input int r3, input int c3,
                       input logic [4:0] col);
    int w;
    w = 0;
    while (!lock_ready && w < 300) begin
      tick();
      w++;
    end
    if (!lock_ready) chk("ready_timeout", 0, 1);
    lock_rows  = {RW'(r3), RW'(r2), RW'(r1), RW'(r0)};
    lock_cols  = {CLW'(c3), CLW'(c2), CLW'(c1), CLW'(c0)};
    lock_color = col;
    lock_valid = 1'b1;
    tick();
    lock_valid = 1'b0;
  endtask

  task automatic lock4(input int r0, input int c0, input int r1, input int c1,
                       input int r2, input int c2, input int r3, input int c3,
                       input logic [4:0] col, output int l);
    offer(r0, c0, r1, c1, r2, c2, r3, c3, col);
    l = 0;
    while (!clear_pulse && l < 300) begin
      tick();
      l++;
    end
    if (!clear_pulse) chk("pulse_timeout", 0, 1);
  endtask

  logic [4:0] v;

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_ready", lock_ready, 1);
    chk("rst_score", score, 0);
    chk("rst_best", best_score, 0);
    chk("rst_gover", game_over, 0);
    chk("rst_pulse", clear_pulse, 0);
    chk("rst_count", clear_count, 0);
    sweep("rst_sweep", 0, 19);

    // 2: 2x2 block at the floor, no clear
    lock4(18, 4, 18, 5, 19, 4, 19, 5, 5'd3, lat);
    chk("t2_lat", lat, 22);
    chk("t2_count", clear_count, 0);
    chk("t2_score", score, 0);
    tick();
    chk("t2_pulse_drop", clear_pulse, 0);
    vid(19, 5, v);
    chk("t2_vid_19_5", v, 3);
    vid(17, 5, v);
    chk("t2_vid_17_5", v, 0);
    vid(25, 3, v);
    chk("t2_vid_oob", v, 0);
    probe_row = 6'd19; probe_col = 5'd5; #1;
    chk("probe_occ", probe_occ, 1);
    probe_row = 6'd17; #1;
    chk("probe_free", probe_occ, 0);
    probe_row = 6'h3F; #1;
    chk("probe_row_neg", probe_occ, 1);
    probe_row = 6'd20; #1;
    chk("probe_row_big", probe_occ, 1);
    probe_row = 6'd0; probe_col = 5'd10; #1;
    chk("probe_col_big", probe_occ, 1);
    probe_col = 5'h1F; #1;
    chk("probe_col_neg", probe_occ, 1);

    // 3: single line clear
    do_reset();
    lock4(19, 0, 19, 1, 19, 2, 19, 3, 5'd1, lat);
    lock4(19, 4, 19, 5, 19, 6, 19, 7, 5'd1, lat);
    lock4(19, 8, 19, 8, 19, 8, 19, 8, 5'd1, lat);
    lock4(18, 0, 18, 0, 18, 0, 18, 0, 5'd2, lat);
    chk("t3_pre_count", clear_count, 0);
    lock4(19, 9, 19, 9, 19, 9, 19, 9, 5'd4, lat);
    chk("t3_lat", lat, 43);
    chk("t3_count", clear_count, 1);
    chk("t3_score", score, 1);
    chk("t3_best", best_score, 1);
    vid(19, 0, v);
    chk("t3_vid_19_0", v, 2);
    vid(19, 9, v);
    chk("t3_vid_19_9", v, 0);
    sweep("t3_row18", 18, 18);

    // 4: tetris
    do_reset();
    for (int r = 16; r <= 19; r++) begin
      lock4(r, 0, r, 1, r, 2, r, 3, 5'd1, lat);
      lock4(r, 4, r, 5, r, 6, r, 7, 5'd1, lat);
    end
    lock4(16, 8, 17, 8, 18, 8, 19, 8, 5'd1, lat);
    chk("t4_pre_score", score, 0);
    lock4(16, 9, 17, 9, 18, 9, 19, 9, 5'd6, lat);
    chk("t4_lat", lat, 106);
    chk("t4_count", clear_count, 4);
    chk("t4_score", score, 8);
    chk("t4_best", best_score, 8);
    sweep("t4_floor", 16, 19);

    // 5: game over, refused offer, new game
    lock4(0, 0, 1, 0, 2, 0, 3, 0, 5'd5, lat);
    chk("t5_count", clear_count, 0);
    chk("t5_gover", game_over, 1);
    chk("t5_ready", lock_ready, 0);
    chk("t5_score", score, 8);
    lock_rows  = {RW'(10), RW'(10), RW'(10), RW'(10)};
    lock_cols  = '0;
    lock_color = 5'd7;
    lock_valid = 1'b1;
    tick(); tick(); tick();
    chk("t5_refused_busy", busy, 0);
    lock_valid = 1'b0;
    vid(10, 0, v);
    chk("t5_refused_cell", v, 0);
    clr_game = 1'b1;
    tick();
    clr_game = 1'b0;
    chk("t5_clr_gover", game_over, 0);
    chk("t5_clr_score", score, 0);
    chk("t5_clr_best", best_score, 8);
    chk("t5_clr_ready", lock_ready, 1);
    sweep("t5_clr_board", 0, 19);

    // 6: reset in the middle of a shift
    lock4(19, 0, 19, 1, 19, 2, 19, 3, 5'd1, lat);
    lock4(19, 4, 19, 5, 19, 6, 19, 7, 5'd1, lat);
    offer(19, 8, 19, 9, 19, 8, 19, 9, 5'd2);
    tick(); tick(); tick(); tick(); tick();
    chk("t6_busy_mid", busy, 1);
    probe_row = 6'd5; probe_col = 5'd5; #1;
    chk("t6_probe_busy", probe_occ, 1);
    clr_game = 1'b1;
    tick();
    clr_game = 1'b0;
    chk("t6_clr_ignored", busy, 1);
    do_reset();
    chk("t6_busy", busy, 0);
    chk("t6_ready", lock_ready, 1);
    chk("t6_score", score, 0);
    chk("t6_best", best_score, 0);
    chk("t6_pulse", clear_pulse, 0);
    sweep("t6_board", 0, 19);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
